led_pattern_scheduler: RTL and testbench

Shares the MiniZed bi-color LED (green/red on Arduino A-port) and the blue DONE LED between several requesters. A round-robin arbiter picks one requester. The block latches that requester's 8-step LED pattern and plays it back at a fixed step rate, then forces a blank gap before the next grant. It sits between user logic and the LED pins, clocked by the PS fclk_clk[0] domain.

---
 rtl/led_sched_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/led_pattern_scheduler.sv | 161 ++++++++++++++++
 tb/tb_led_pattern_scheduler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_sched_pkg.sv
// Shared types and LED step codes for the LED pattern scheduler.
// A step is a 2-bit {red, green} code.
package led_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } state_t;

   localparam logic [1:0] LED_OFF   = 2'b00;
   localparam logic [1:0] LED_GREEN = 2'b01;
   localparam logic [1:0] LED_RED   = 2'b10;
   localparam logic [1:0] LED_BOTH  = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: picks the first set request bit
// starting at ptr and wrapping modulo NUM_REQ.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int PTR_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] sel,
   output logic [PTR_W-1:0]   idx,
   output logic               valid
);

   int pos;

   always_comb begin
      sel   = '0;
      idx   = '0;
      valid = 1'b0;
      pos   = 0;
      for (int off = 0; off < NUM_REQ; off++) begin
         pos = (int'(ptr) + off) % NUM_REQ;
         if (!valid && req[pos]) begin
            valid    = 1'b1;
            sel[pos] = 1'b1;
            idx      = PTR_W'(pos);
         end
      end
   end

endmodule

// File: rtl/led_pattern_scheduler.sv
// Round-robin scheduler that lends the bi-color and DONE LEDs to one
// requester at a time, plays its latched pattern, then blanks for one step.
module led_pattern_scheduler
   import led_sched_pkg::*;
#(
   parameter real CLK_FREQUENCY = 100.0e6,
   parameter real STEP_PERIOD   = 0.125,
   parameter int  NUM_REQ       = 4,
   parameter int  PATTERN_LEN   = 8
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*PATTERN_LEN*2-1:0] pattern,
   output logic [NUM_REQ-1:0]             grant,
   output logic [NUM_REQ-1:0]             done,
   output logic                           led_g,
   output logic                           led_r,
   output logic                           led_b,
   output logic                           busy
);

   localparam int STEP_COUNT = int'(CLK_FREQUENCY * STEP_PERIOD);
   localparam int STEP_WIDTH = (STEP_COUNT > 1) ? $clog2(STEP_COUNT) : 1;
   localparam int IDX_W      = $clog2(PATTERN_LEN);
   localparam int PTR_W      = $clog2(NUM_REQ);
   localparam int SLICE_W    = 2 * PATTERN_LEN;

   localparam logic [STEP_WIDTH-1:0] STEP_LAST = STEP_WIDTH'(STEP_COUNT - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(PATTERN_LEN - 1);
   localparam logic [PTR_W-1:0]      PTR_LAST  = PTR_W'(NUM_REQ - 1);

   if (STEP_COUNT < 2) begin : g_bad_step
      $error("led_pattern_scheduler: STEP_COUNT must be at least 2");
   end
   if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_req
      $error("led_pattern_scheduler: NUM_REQ must be in 2..8");
   end
   if (PATTERN_LEN < 2 || PATTERN_LEN > 16) begin : g_bad_len
      $error("led_pattern_scheduler: PATTERN_LEN must be in 2..16");
   end

   function automatic logic [1:0] step_code(input logic [SLICE_W-1:0] pat,
                                            input logic [IDX_W-1:0]   k);
      return pat[{k, 1'b0} +: 2];
   endfunction

   state_t                  state_q, state_d;
   logic [STEP_WIDTH-1:0]   cnt_q;
   logic [IDX_W-1:0]        idx_q;
   logic [PTR_W-1:0]        ptr_q;
   logic [PTR_W-1:0]        owner_q;
   logic [NUM_REQ-1:0]      owner_oh;
   logic [NUM_REQ-1:0]      done_q;
   logic [SLICE_W-1:0]      pat_q;
   logic [1:0]              code;
   logic                    step_wrap;

   logic [NUM_REQ-1:0]      arb_sel;
   logic [PTR_W-1:0]        arb_idx;
   logic                    arb_valid;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_arb (
      .req   (req),
      .ptr   (ptr_q),
      .sel   (arb_sel),
      .idx   (arb_idx),
      .valid (arb_valid)
   );

   assign step_wrap = (cnt_q == STEP_LAST);
   assign owner_oh  = NUM_REQ'(1) << owner_q;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (arb_valid) state_d = PLAY;
         PLAY:    if (step_wrap && idx_q == IDX_LAST) state_d = GAP;
         GAP:     if (step_wrap) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Step timing, round-robin pointer, owner and done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         ptr_q   <= '0;
         owner_q <= '0;
         done_q  <= '0;
      end else begin
         done_q <= '0;
         case (state_q)
            IDLE: begin
               if (arb_valid) begin
                  cnt_q   <= '0;
                  idx_q   <= '0;
                  owner_q <= arb_idx;
                  ptr_q   <= (arb_idx == PTR_LAST) ? '0 : arb_idx + 1'b1;
               end
            end
            PLAY: begin
               if (step_wrap) begin
                  cnt_q <= '0;
                  if (idx_q != IDX_LAST) idx_q <= idx_q + 1'b1;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            GAP: begin
               if (step_wrap) begin
                  cnt_q  <= '0;
                  done_q <= owner_oh;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: cnt_q <= '0;
         endcase
      end
   end

   // Pattern is captured only at grant; later input changes are ignored
   always_ff @(posedge clk) begin
      if (state_q == IDLE && arb_valid) pat_q <= pattern[arb_idx*SLICE_W +: SLICE_W];
   end

   // Output decode; everything is forced off outside PLAY
   always_comb begin
      grant = '0;
      code  = LED_OFF;
      led_b = 1'b0;
      busy  = 1'b0;
      case (state_q)
         PLAY: begin
            grant = owner_oh;
            code  = step_code(pat_q, idx_q);
            led_b = 1'b1;
            busy  = 1'b1;
         end
         GAP:     busy = 1'b1;
         default: ;
      endcase
   end

   assign led_g = code[0];
   assign led_r = code[1];
   assign done  = done_q;

endmodule

// File: tb/tb_led_pattern_scheduler.sv
// Directed bench for led_pattern_scheduler with STEP_COUNT = 4,
// NUM_REQ = 4 and PATTERN_LEN = 8.
module tb_led_pattern_scheduler;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  req;
   logic [63:0] pattern;
   logic [3:0]  grant;
   logic [3:0]  done;
   logic        led_g, led_r, led_b, busy;

   int n_vec = 0;
   int n_bad = 0;

   typedef struct {
      int         cycles;
      logic [3:0] grant;
      logic [1:0] rg;
      logic       b;
      logic       busy;
      logic [3:0] done;
   } vec_t;

   vec_t       tbl [10];
   logic [3:0] order [5];

   always #5 clk = ~clk;

   led_pattern_scheduler #(
      .CLK_FREQUENCY (8.0),
      .STEP_PERIOD   (0.5),
      .NUM_REQ       (4),
      .PATTERN_LEN   (8)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .pattern (pattern),
      .grant   (grant),
      .done    (done),
      .led_g   (led_g),
      .led_r   (led_r),
      .led_b   (led_b),
      .busy    (busy)
   );

   function automatic vec_t mk(input int c, input logic [3:0] g, input logic [1:0] rg,
                               input logic b, input logic bz, input logic [3:0] d);
      vec_t v;
      v.cycles = c;
      v.grant  = g;
      v.rg     = rg;
      v.b      = b;
      v.busy   = bz;
      v.done   = d;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] rg,
                          input logic b, input logic bz, input logic [3:0] d);
      chk({tag, " grant"}, 32'(grant), 32'(g));
      chk({tag, " led_rg"}, 32'({led_r, led_g}), 32'(rg));
      chk({tag, " led_b"}, 32'(led_b), 32'(b));
      chk({tag, " busy"}, 32'(busy), 32'(bz));
      chk({tag, " done"}, 32'(done), 32'(d));
   endtask

   // Walks the table one clock at a time; req drops after the grant clock
   // and an optional pattern rewrite lands at clock chg_cyc.
   task automatic run_tbl(input int nrows, input string tag, input int chg_cyc,
                          input int slot, input logic [15:0] newpat);
      int cyc = 0;
      for (int r = 0; r < nrows; r++) begin
         for (int c = 0; c < tbl[r].cycles; c++) begin
            tick;
            cyc++;
            if (cyc == 1) req = 4'b0000;
            if (cyc == chg_cyc) pattern[slot*16 +: 16] = newpat;
            chk_all($sformatf("%s c%0d", tag, cyc), tbl[r].grant, tbl[r].rg,
                    tbl[r].b, tbl[r].busy, tbl[r].done);
         end
      end
   endtask

   task automatic wait_done(input string tag, input logic [3:0] exp);
      bit seen = 1'b0;
      for (int k = 0; k < 60 && !seen; k++) begin
         tick;
         if (done != 4'b0000) seen = 1'b1;
      end
      chk({tag, " done"}, 32'(done), 32'(exp));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      req     = 4'hF;
      pattern = '0;
      order[0] = 4'b0001;
      order[1] = 4'b0010;
      order[2] = 4'b0100;
      order[3] = 4'b1000;
      order[4] = 4'b0001;

      // reset held with all requests pending
      tick;
      tick;
      chk_all("reset", 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);

      // release: requester 0 one clock later, then strict round-robin
      rst_n = 1'b1;
      tick;
      chk("rr grant0", 32'(grant), 32'(order[0]));
      for (int k = 1; k < 5; k++) begin
         wait_done($sformatf("rr %0d", k - 1), order[k-1]);
         tick;
         chk($sformatf("rr grant%0d", k), 32'(grant), 32'(order[k]));
      end
      req = 4'b0000;
      wait_done("rr 4", 4'b0001);

      // single requester 2 with steps 0,1,2,3,0,1,2,3
      pattern[32 +: 16] = 16'hE4E4;
      req = 4'b0100;
      tbl[0] = mk(4, 4'b0100, 2'b00, 1'b1, 1'b1, 4'b0000);
      tbl[1] = mk(4, 4'b0100, 2'b01, 1'b1, 1'b1, 4'b0000);
      tbl[2] = mk(4, 4'b0100, 2'b10, 1'b1, 1'b1, 4'b0000);
      tbl[3] = mk(4, 4'b0100, 2'b11, 1'b1, 1'b1, 4'b0000);
      tbl[4] = mk(4, 4'b0100, 2'b00, 1'b1, 1'b1, 4'b0000);
      tbl[5] = mk(4, 4'b0100, 2'b01, 1'b1, 1'b1, 4'b0000);
      tbl[6] = mk(4, 4'b0100, 2'b10, 1'b1, 1'b1, 4'b0000);
      tbl[7] = mk(4, 4'b0100, 2'b11, 1'b1, 1'b1, 4'b0000);
      tbl[8] = mk(4, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000);
      tbl[9] = mk(1, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0100);
      run_tbl(10, "play2", 0, 0, 16'h0000);

      // req[1] pulsed once; pattern rewritten mid-playback is ignored
      pattern[16 +: 16] = 16'h1B1B;
      req = 4'b0010;
      tbl[0] = mk(4, 4'b0010, 2'b11, 1'b1, 1'b1, 4'b0000);
      tbl[1] = mk(4, 4'b0010, 2'b10, 1'b1, 1'b1, 4'b0000);
      tbl[2] = mk(4, 4'b0010, 2'b01, 1'b1, 1'b1, 4'b0000);
      tbl[3] = mk(4, 4'b0010, 2'b00, 1'b1, 1'b1, 4'b0000);
      tbl[4] = mk(4, 4'b0010, 2'b11, 1'b1, 1'b1, 4'b0000);
      tbl[5] = mk(4, 4'b0010, 2'b10, 1'b1, 1'b1, 4'b0000);
      tbl[6] = mk(4, 4'b0010, 2'b01, 1'b1, 1'b1, 4'b0000);
      tbl[7] = mk(4, 4'b0010, 2'b00, 1'b1, 1'b1, 4'b0000);
      tbl[8] = mk(4, 4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000);
      tbl[9] = mk(1, 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0010);
      run_tbl(10, "hold4", 5, 1, 16'h5555);

      // reset asserted at clock 10 of playback
      pattern[0 +: 16] = 16'hFFFF;
      req = 4'b0001;
      for (int c = 1; c <= 10; c++) begin
         tick;
         if (c == 1) req = 4'b0000;
         chk($sformatf("rst5 grant c%0d", c), 32'(grant), 32'(4'b0001));
         chk($sformatf("rst5 led_rg c%0d", c), 32'({led_r, led_g}), 32'(2'b11));
      end
      rst_n = 1'b0;
      #1;
      chk_all("rst5 async", 4'b0000, 2'b00, 1'b0, 1'b0, 4'b0000);
      for (int c = 0; c < 3; c++) begin
         tick;
         chk($sformatf("rst5 no done %0d", c), 32'(done), 32'(4'b0000));
      end
      req   = 4'b0010;
      rst_n = 1'b1;
      tick;
      chk("rst5 regrant", 32'(grant), 32'(4'b0010));
      req = 4'b0000;
      wait_done("rst5", 4'b0010);

      // blank pattern: DONE LED alone for the whole playback
      pattern[48 +: 16] = 16'h0000;
      req = 4'b1000;
      tbl[0] = mk(32, 4'b1000, 2'b00, 1'b1, 1'b1, 4'b0000);
      tbl[1] = mk(4,  4'b0000, 2'b00, 1'b0, 1'b1, 4'b0000);
      tbl[2] = mk(1,  4'b0000, 2'b00, 1'b0, 1'b0, 4'b1000);
      run_tbl(3, "blank6", 0, 0, 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
